// File: rtl/gpu_line_raster.sv
// gpu_line_raster: Bresenham line rasteriser writing pixels straight into SRAM.
// Define GPU_CLEAR_EN to add the I_CLR_REQ full-framebuffer clear command.
module gpu_line_raster #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 400,
  parameter int COORD_W  = 10,
  parameter int ADDR_W   = 18,
  parameter int COLOR_W  = 16
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_VIDEO_ON,
`ifdef GPU_CLEAR_EN
  input  logic               I_CLR_REQ,
`endif
  input  logic               I_CMD_VALID,
  output logic               O_CMD_READY,
  input  logic [COORD_W-1:0] I_X0,
  input  logic [COORD_W-1:0] I_Y0,
  input  logic [COORD_W-1:0] I_X1,
  input  logic [COORD_W-1:0] I_Y1,
  input  logic [COLOR_W-1:0] I_COLOR,
  output logic [ADDR_W-1:0]  O_GPU_ADDR,
  output logic [COLOR_W-1:0] O_GPU_DATA,
  output logic               O_GPU_WRITE,
  output logic               O_GPU_READ,
  output logic               O_BUSY,
  output logic               O_DONE,
  output logic [15:0]        O_PIX_COUNT
);

  localparam int CW = COORD_W + 2;

  localparam logic signed [CW-1:0] P1  = CW'(1);
  localparam logic signed [CW-1:0] M1  = '1;
  localparam logic signed [CW-1:0] W_S = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] H_S = CW'(SCREEN_H);
  localparam logic [ADDR_W-1:0]    W_A = ADDR_W'(SCREEN_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_CLEAR
  } state_e;

  state_e state_q, state_d;

  logic signed [CW-1:0] x_q, x_d, y_q, y_d;
  logic signed [CW-1:0] x1_q, x1_d, y1_q, y1_d;
  logic signed [CW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic signed [CW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic signed [CW-1:0] err_q, err_d;

  logic [COLOR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               wr_q, wr_d;
  logic               done_q, done_d;
  logic [15:0]        cnt_q, cnt_d;

`ifdef GPU_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  logic [ADDR_W-1:0] clr_q, clr_d;
`endif

  logic signed [CW-1:0] e2;
  logic                 inb;
  logic                 last;
  logic [ADDR_W-1:0]    pix_addr;

  assign e2   = err_q <<< 1;
  assign inb  = (x_q < W_S) && (y_q < H_S);
  assign last = (x_q == x1_q) && (y_q == y1_q);

  // Row-major address; clipped pixels never reach the bus.
  assign pix_addr = ADDR_W'(y_q[COORD_W-1:0]) * W_A
                  + ADDR_W'(x_q[COORD_W-1:0]);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;
    col_d   = col_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef GPU_CLEAR_EN
    clr_d   = clr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
`ifdef GPU_CLEAR_EN
        if (I_CLR_REQ) begin
          state_d = S_CLEAR;
          col_d   = I_COLOR;
          clr_d   = '0;
        end else if (I_CMD_VALID) begin
`else
        if (I_CMD_VALID) begin
`endif
          state_d = S_SETUP;
          x_d     = {2'b00, I_X0};
          y_d     = {2'b00, I_Y0};
          x1_d    = {2'b00, I_X1};
          y1_d    = {2'b00, I_Y1};
          col_d   = I_COLOR;
        end
      end

      S_SETUP: begin
        dx_d    = (x1_q >= x_q) ? x1_q - x_q : x_q - x1_q;
        dy_d    = (y1_q >= y_q) ? y_q - y1_q : y1_q - y_q;
        sx_d    = (x1_q >= x_q) ? P1 : M1;
        sy_d    = (y1_q >= y_q) ? P1 : M1;
        err_d   = dx_d + dy_d;
        state_d = S_DRAW;
      end

      S_DRAW: begin
        if (!I_VIDEO_ON) begin
          wr_d   = inb;
          addr_d = pix_addr;
          data_d = col_q;
          cnt_d  = cnt_q + 16'(inb);
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            if (e2 >= dy_q) begin
              err_d = err_d + dy_q;
              x_d   = x_q + sx_q;
            end
            if (e2 <= dx_q) begin
              err_d = err_d + dx_q;
              y_d   = y_q + sy_q;
            end
          end
        end
      end

`ifdef GPU_CLEAR_EN
      S_CLEAR: begin
        if (!I_VIDEO_ON) begin
          wr_d   = 1'b1;
          addr_d = clr_q;
          data_d = col_q;
          cnt_d  = cnt_q + 16'd1;
          if (clr_q == CLR_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            clr_d = clr_q + ADDR_W'(1);
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      err_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef GPU_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef GPU_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  assign O_CMD_READY = (state_q == S_IDLE);
  assign O_BUSY      = (state_q != S_IDLE);
  assign O_GPU_ADDR  = addr_q;
  assign O_GPU_DATA  = data_q;
  assign O_GPU_WRITE = wr_q;
  assign O_GPU_READ  = 1'b0;
  assign O_DONE      = done_q;
  assign O_PIX_COUNT = cnt_q;

endmodule
